// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for a MIPS-style datapath with a retired-instruction counter.
// Optional macro CTRL_ILLEGAL_TRAP_EN: undefined opcodes set illegal_op and park the FSM in TRAP until rst.
module multicycle_control #(
    parameter int OPCODE_W = 3,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic [1:0]          sig_regDst,
    output logic [1:0]          sig_memtoReg,
    output logic                sig_ALUsrc,
    output logic [1:0]          sig_ALUop,
    output logic                sig_jump,
    output logic                sig_branch,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    instr_count
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_SLTI  = 3'b001;
    localparam logic [2:0] OP_J     = 3'b010;
    localparam logic [2:0] OP_JAL   = 3'b011;
    localparam logic [2:0] OP_LW    = 3'b100;
    localparam logic [2:0] OP_SW    = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_ADDI  = 3'b111;

    logic [2:0]       r_state;
    logic [2:0]       r_opQ;
    logic [CNT_W-1:0] r_instrCount;

    logic [2:0] w_nextState;
    logic       w_opDefined;
    logic       w_pcWrite;
    logic       w_irWrite;
    logic       w_memRead;
    logic       w_memWrite;
    logic       w_regWrite;
    logic [1:0] w_regDst;
    logic [1:0] w_memtoReg;
    logic       w_aluSrc;
    logic [1:0] w_aluOp;
    logic       w_jump;
    logic       w_branch;
    logic       w_instrDone;

    // Only the low three opcode bits carry meaning; anything above them marks an undefined instruction.
    assign w_opDefined = ((opcode >> 3) == '0);

    always_comb begin
        w_nextState = r_state;
        w_pcWrite   = 1'b0;
        w_irWrite   = 1'b0;
        w_memRead   = 1'b0;
        w_memWrite  = 1'b0;
        w_regWrite  = 1'b0;
        w_regDst    = 2'b00;
        w_memtoReg  = 2'b00;
        w_aluSrc    = 1'b0;
        w_aluOp     = 2'b00;
        w_jump      = 1'b0;
        w_branch    = 1'b0;
        w_instrDone = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memRead = 1'b1;
                if (mem_ready) begin
                    w_irWrite   = 1'b1;
                    w_pcWrite   = 1'b1;
                    w_nextState = S_DECODE;
                end
            end
            // DECODE still looks at the live opcode; op_q only becomes valid after this state.
            S_DECODE: begin
                if (!w_opDefined) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    w_nextState = S_TRAP;
`else
                    w_instrDone = 1'b1;
                    w_nextState = S_FETCH;
`endif
                end else if (opcode[2:0] == OP_J) begin
                    w_jump      = 1'b1;
                    w_pcWrite   = 1'b1;
                    w_instrDone = 1'b1;
                    w_nextState = S_FETCH;
                end else begin
                    w_nextState = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_opQ)
                    OP_RTYPE: begin
                        w_aluOp     = 2'b10;
                        w_nextState = S_WB;
                    end
                    OP_SLTI: begin
                        w_aluOp     = 2'b11;
                        w_aluSrc    = 1'b1;
                        w_nextState = S_WB;
                    end
                    OP_ADDI: begin
                        w_aluSrc    = 1'b1;
                        w_nextState = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        w_aluSrc    = 1'b1;
                        w_nextState = S_MEM;
                    end
                    OP_BEQ: begin
                        w_aluOp     = 2'b01;
                        w_branch    = 1'b1;
                        w_instrDone = 1'b1;
                        w_nextState = S_FETCH;
                    end
                    OP_JAL:  w_nextState = S_WB;
                    default: w_nextState = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (r_opQ == OP_LW) begin
                    w_memRead = 1'b1;
                    if (mem_ready) w_nextState = S_WB;
                end else if (r_opQ == OP_SW) begin
                    w_memWrite = 1'b1;
                    if (mem_ready) begin
                        w_instrDone = 1'b1;
                        w_nextState = S_FETCH;
                    end
                end else begin
                    w_nextState = S_FETCH;
                end
            end
            S_WB: begin
                w_regWrite  = 1'b1;
                w_instrDone = 1'b1;
                w_nextState = S_FETCH;
                case (r_opQ)
                    OP_RTYPE: w_regDst = 2'b01;
                    OP_LW:    w_memtoReg = 2'b01;
                    OP_JAL: begin
                        w_regDst   = 2'b10;
                        w_memtoReg = 2'b10;
                        w_jump     = 1'b1;
                        w_pcWrite  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_TRAP:  w_nextState = S_TRAP;
            default: w_nextState = S_FETCH;
        endcase
    end

    // Reset masks every strobe combinationally so an abandoned instruction cannot write anything.
    assign pc_write     = w_pcWrite & ~rst;
    assign ir_write     = w_irWrite & ~rst;
    assign mem_read     = w_memRead & ~rst;
    assign mem_write    = w_memWrite & ~rst;
    assign reg_write    = w_regWrite & ~rst;
    assign sig_regDst   = rst ? 2'b00 : w_regDst;
    assign sig_memtoReg = rst ? 2'b00 : w_memtoReg;
    assign sig_ALUsrc   = w_aluSrc & ~rst;
    assign sig_ALUop    = rst ? 2'b00 : w_aluOp;
    assign sig_jump     = w_jump & ~rst;
    assign sig_branch   = w_branch & ~rst;
    assign instr_done   = w_instrDone & ~rst;
    assign instr_count  = r_instrCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_opQ        <= 3'b000;
            r_instrCount <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_DECODE) r_opQ <= opcode[2:0];
            if (w_instrDone) r_instrCount <= r_instrCount + CNT_W'(1);
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegalOp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegalOp <= 1'b0;
        end else if (r_state == S_DECODE && !w_opDefined) begin
            r_illegalOp <= 1'b1;
        end
    end

    assign illegal_op = r_illegalOp;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: random instruction stream with random memory stalls plus
// directed reset, counter-wrap and undefined-opcode cases; follows CTRL_ILLEGAL_TRAP_EN if defined.
module tb_multicycle_control;

    localparam int OPCODE_W = 4;
    localparam int CNT_W    = 4;
    localparam int NUM_RAND = 60;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_SLTI  = 4'd1;
    localparam logic [3:0] OP_J     = 4'd2;
    localparam logic [3:0] OP_JAL   = 4'd3;
    localparam logic [3:0] OP_LW    = 4'd4;
    localparam logic [3:0] OP_SW    = 4'd5;
    localparam logic [3:0] OP_BEQ   = 4'd6;
    localparam logic [3:0] OP_ADDI  = 4'd7;

    logic                clk = 1'b0;
    logic                rst;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write, ir_write, mem_read, mem_write, reg_write;
    logic [1:0]          sig_regDst, sig_memtoReg, sig_ALUop;
    logic                sig_ALUsrc, sig_jump, sig_branch, instr_done, illegal_op;
    logic [CNT_W-1:0]    instr_count;

    multicycle_control #(.OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .sig_regDst(sig_regDst), .sig_memtoReg(sig_memtoReg),
        .sig_ALUsrc(sig_ALUsrc), .sig_ALUop(sig_ALUop), .sig_jump(sig_jump),
        .sig_branch(sig_branch), .instr_done(instr_done), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Per-instruction summary of what the control unit must do, derived from the opcode rules.
    typedef struct {
        int lat; int rd; int wr; int rw; int pcw; int irw; int jmp; int br;
        int src; int aluOp; int regDst; int m2r; int cnt;
    } expT;

    expT expQ[$];
    int  errorCount = 0;
    int  checkCount = 0;
    bit  monEnable  = 1'b0;

    task automatic checkOutput(input string name, input int act, input int req);
        checkCount++;
        if (act != req) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int outVec();
        return int'({pc_write, ir_write, mem_read, mem_write, reg_write, sig_regDst, sig_memtoReg,
                     sig_ALUsrc, sig_ALUop, sig_jump, sig_branch, instr_done});
    endfunction

    // Builds the per-cycle mem_ready schedule, predicts the outcome, then drives it cycle by cycle.
    int expCount = 0;

    task automatic applyStimulus(input logic [3:0] op, input int fs, input int ms);
        bit   sched[$];
        expT  e;
        bit   isLw  = (op == OP_LW);
        bit   isSw  = (op == OP_SW);
        bit   isJ   = (op == OP_J) || (op > 4'd7);
        bit   isBeq = (op == OP_BEQ);
        for (int i = 0; i < fs; i++) sched.push_back(1'b0);
        sched.push_back(1'b1);
        sched.push_back(1'($urandom_range(0, 1)));
        if (!isJ) begin
            sched.push_back(1'($urandom_range(0, 1)));
            if (isLw || isSw) begin
                for (int i = 0; i < ms; i++) sched.push_back(1'b0);
                sched.push_back(1'b1);
            end
            if (!isBeq && !isSw) sched.push_back(1'($urandom_range(0, 1)));
        end
        e.lat    = sched.size();
        e.rd     = fs + 1 + (isLw ? ms + 1 : 0);
        e.wr     = isSw ? ms + 1 : 0;
        e.rw     = (op == OP_RTYPE || op == OP_SLTI || op == OP_ADDI || isLw || op == OP_JAL) ? 1 : 0;
        e.jmp    = (op == OP_J || op == OP_JAL) ? 1 : 0;
        e.pcw    = 1 + e.jmp;
        e.irw    = 1;
        e.br     = isBeq ? 1 : 0;
        e.src    = (op == OP_SLTI || op == OP_ADDI || isLw || isSw) ? 1 : 0;
        e.aluOp  = (op == OP_RTYPE) ? 2 : (op == OP_SLTI) ? 3 : isBeq ? 1 : 0;
        e.regDst = (op == OP_RTYPE) ? 1 : (op == OP_JAL) ? 2 : 0;
        e.m2r    = isLw ? 1 : (op == OP_JAL) ? 2 : 0;
        e.cnt    = expCount % (1 << CNT_W);
        expCount++;
        expQ.push_back(e);
        opcode = op;
        foreach (sched[i]) begin
            mem_ready = sched[i];
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
    endtask

    // Monitor: accumulates strobe activity per instruction and scores it on each instr_done pulse.
    int  accCycles, accRd, accWr, accRw, accPcw, accIrw, accJmp, accBr, accSrc, accAlu, accOverlap;
    expT got;

    task automatic clearAcc();
        accCycles = 0; accRd = 0; accWr = 0; accRw = 0; accPcw = 0; accIrw = 0;
        accJmp = 0; accBr = 0; accSrc = 0; accAlu = 0; accOverlap = 0;
    endtask

    always @(negedge clk) begin
        if (!monEnable) begin
            clearAcc();
        end else begin
            accCycles++;
            accRd  += int'(mem_read);
            accWr  += int'(mem_write);
            accRw  += int'(reg_write);
            accPcw += int'(pc_write);
            accIrw += int'(ir_write);
            accJmp += int'(sig_jump);
            accBr  += int'(sig_branch);
            accSrc += int'(sig_ALUsrc);
            accAlu |= int'(sig_ALUop);
            if (mem_read && mem_write) accOverlap++;
            if (instr_done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    got = expQ.pop_front();
                    checkOutput("latency", accCycles, got.lat);
                    checkOutput("mem_read_cycles", accRd, got.rd);
                    checkOutput("mem_write_cycles", accWr, got.wr);
                    checkOutput("reg_write_cycles", accRw, got.rw);
                    checkOutput("pc_write_cycles", accPcw, got.pcw);
                    checkOutput("ir_write_cycles", accIrw, got.irw);
                    checkOutput("jump_cycles", accJmp, got.jmp);
                    checkOutput("branch_cycles", accBr, got.br);
                    checkOutput("alusrc_cycles", accSrc, got.src);
                    checkOutput("aluop", accAlu, got.aluOp);
                    checkOutput("regdst_at_done", int'(sig_regDst), got.regDst);
                    checkOutput("memtoreg_at_done", int'(sig_memtoReg), got.m2r);
                    checkOutput("count_at_done", int'(instr_count), got.cnt);
                    checkOutput("rd_wr_overlap", accOverlap, 0);
                end
                clearAcc();
            end
        end
    end

    logic [3:0] op;

    initial begin
        rst = 1'b1; mem_ready = 1'b1; opcode = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", outVec(), 0);
        checkOutput("reset_count", int'(instr_count), 0);
        checkOutput("reset_illegal", int'(illegal_op), 0);
        @(posedge clk);
        #1;
        rst = 1'b0; mem_ready = 1'b0;
        $display("[TB] random instruction stream");
        monEnable = 1'b1;
        for (int n = 0; n < NUM_RAND; n++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            op = 4'($urandom_range(0, 7));
`else
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
`endif
            applyStimulus(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
        monEnable = 1'b0;
        checkOutput("pending_expectations", expQ.size(), 0);
        @(negedge clk);
        checkOutput("count_after_stream", int'(instr_count), expCount % (1 << CNT_W));

        $display("[TB] reset during sw MEM");
        @(posedge clk); #1;
        opcode = OP_SW; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("sw_mem_write_stall", int'(mem_write), 1);
        @(posedge clk); #1;
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("sw_reset_mem_write", int'(mem_write), 0);
        checkOutput("sw_reset_done", int'(instr_done), 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_count", int'(instr_count), 0);
        checkOutput("post_reset_fetch", int'(mem_read), 1);

        $display("[TB] seventeen jumps");
        @(posedge clk); #1;
        opcode = OP_J;
        for (int n = 0; n < 17; n++) begin
            mem_ready = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("count_wrap", int'(instr_count), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] undefined opcode");
        opcode = 4'b1010; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
`ifdef CTRL_ILLEGAL_TRAP_EN
        checkOutput("trap_decode_done", int'(instr_done), 0);
        @(posedge clk); #1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checkOutput("trap_outputs", outVec(), 0);
            checkOutput("trap_illegal", int'(illegal_op), 1);
            checkOutput("trap_count", int'(instr_count), 0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("trap_cleared", int'(illegal_op), 0);
`else
        checkOutput("nop_decode_done", int'(instr_done), 1);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("nop_count", int'(instr_count), 1);
        checkOutput("nop_back_to_fetch", int'(mem_read), 1);
        checkOutput("nop_illegal", int'(illegal_op), 0);
`endif
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle control unit for the MIPS-style datapath, replacing single-cycle combinational opcode decoding. A registered FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, stalls on a memory ready handshake, and counts retired instructions. It sits between the instruction register/memory interface and the datapath muxes, ALU control, register file and PC.

## Interface
- OPCODE_W, 3, opcode width (≥3); only values 0-7 are defined.
- CNT_W, 32, retired-instruction counter width.

- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  OPCODE_W  opcode field of the instruction register, valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, ir_write  out  1  PC and IR load enables
- mem_read, mem_write  out  1  memory strobes
- reg_write  out  1  register-file write enable
- sig_regDst  out  2  00 = rt, 01 = rd, 10 = r31
- sig_memtoReg  out  2  00 = ALU, 01 = memory, 10 = PC+4
- sig_ALUsrc  out  1  1 = immediate
- sig_ALUop  out  2  00 = add, 01 = sub, 10 = funct, 11 = slt
- sig_jump, sig_branch  out  1  PC source selects
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  sticky undefined-opcode flag (see Configuration)
- instr_count  out  CNT_W  retired instructions

## Operation
- Opcode map: 000 R-type, 001 slti, 010 j, 011 jal, 100 lw, 101 sw, 110 beq, 111 addi.
- The state register uses FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Moore outputs decode from the state and op_q. op_q is the opcode latched on exit from DECODE.
- Any output not listed for a state is 0.
- FETCH: mem_read=1.
  - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: latch op_q.
  - j: sig_jump=1, pc_write=1, instr_done=1, go to FETCH.
  - Defined opcodes other than j go to EXEC.
  - Undefined opcodes are handled per Configuration.
- EXEC:
  - R-type: ALUop=10, go to WB.
  - slti: ALUop=11, ALUsrc=1, go to WB.
  - addi, lw, sw: ALUop=00, ALUsrc=1. addi goes to WB; lw and sw go to MEM.
  - beq: ALUop=01, sig_branch=1, instr_done=1, go to FETCH.
  - jal: no outputs, go to WB.
- MEM:
  - lw: mem_read=1 until mem_ready, then go to WB.
  - sw: mem_write=1 until mem_ready. On mem_ready assert instr_done and go to FETCH.
- WB: reg_write=1, instr_done=1, go to FETCH.
  - R-type: regDst=01, memtoReg=00.
  - slti and addi: regDst=00, memtoReg=00.
  - lw: regDst=00, memtoReg=01.
  - jal: regDst=10, memtoReg=10, sig_jump=1, pc_write=1.
- instr_count increments by 1 on every edge where instr_done=1. It wraps from 2^CNT_W−1 to 0.

## Timing
- Reset:
  - rst=1 at an edge sets state=FETCH, op_q=0, instr_count=0, illegal_op=0.
  - While rst=1, all control outputs are forced to 0.
  - The first FETCH cycle is the cycle after rst deasserts.
- Reset mid-instruction abandons the instruction. No write strobe is issued in the reset cycle and the count does not change.
- Latency with mem_ready held 1: j 2 cycles, beq 3, R/slti/addi/jal/sw 4, lw 5. Each cycle mem_ready=0 in FETCH or MEM adds one cycle.
- mem_ready is ignored outside FETCH and MEM. mem_read and mem_write are never asserted together.
- Strobes are level outputs for the whole state cycle. The datapath samples them on the closing edge.
- opcode must remain stable from DECODE until instr_done, since op_q captures it at the DECODE exit edge.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - An undefined opcode in DECODE (value ≥8, reachable only when OPCODE_W>3) sets illegal_op=1 and enters TRAP.
  - TRAP drives all outputs 0, emits no instr_done, and is left only by rst.
- Not defined:
  - An undefined opcode executes as a NOP: DECODE asserts instr_done and goes to FETCH, and the count increments.
  - illegal_op is tied to 0 and TRAP is unreachable.

## Test plan
- Reset then R-type (000), mem_ready=1 → states 0,1,2,4. reg_write=1 with regDst=01 only in cycle 4. instr_count=1 afterwards.
- lw (100) with mem_ready=0 for 3 MEM cycles → mem_read high 4 MEM cycles, then WB with memtoReg=01. Total 8 cycles.
- Sequence j, beq, jal, sw → done pulses at cycles 2, 5, 9, 13. jal WB asserts regDst=10, memtoReg=10, pc_write=1. instr_count=4.
- rst asserted during MEM of sw with mem_ready=1 → no mem_write that cycle. State=FETCH and count=0 next cycle.
- CNT_W=4, 17 j instructions → instr_count wraps to 1.
- OPCODE_W=4, opcode 1010 → with CTRL_ILLEGAL_TRAP_EN: illegal_op=1, state stays 5, outputs 0. Without it: NOP in 2 cycles, count+1.
